// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Initiator-side front end for the CPU ALU. Commands from decode/issue are
// buffered in a small FIFO and then driven onto the ALU inputs one at a time.
// The unit captures the settled ALU output and returns it, together with the
// command tag, over a valid/ready result interface.
//
// Parameters:
//   OPERAND_LENGTH - width of every operand and result
//   FIFO_DEPTH     - command FIFO entries (power of two, >= 2)
//   TAG_WIDTH      - width of the opaque command tag
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (cmd_ready = FIFO not full)
//   cmd_opd1..cmd_opd4            command operands
//   cmd_mux1_select               comparison operand pair select
//   cmd_mux2_select               result unit select (11 = comparison unit)
//   cmd_op_select, cmd_tag        unit op code and command tag
//   opd1..opd4, alu_*_select      registered ALU stimulus
//   alu_result, comp_result       ALU outputs
//   res_valid / res_ready         result handshake
//   res_data, res_tag             captured result and its tag
//
// Optional build macro ALU_ISSUE_STATS_EN adds the saturating counters
// stat_ops (result handshakes) and stat_stall (cycles stalled by consumer).
// ---------------------------------------------------------------------------
module alu_issue_unit #(
    parameter int OPERAND_LENGTH = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OPERAND_LENGTH-1:0] cmd_opd1,
    input  logic [OPERAND_LENGTH-1:0] cmd_opd2,
    input  logic [OPERAND_LENGTH-1:0] cmd_opd3,
    input  logic [OPERAND_LENGTH-1:0] cmd_opd4,
    input  logic                      cmd_mux1_select,
    input  logic [1:0]                cmd_mux2_select,
    input  logic [3:0]                cmd_op_select,
    input  logic [TAG_WIDTH-1:0]      cmd_tag,
    output logic [OPERAND_LENGTH-1:0] opd1,
    output logic [OPERAND_LENGTH-1:0] opd2,
    output logic [OPERAND_LENGTH-1:0] opd3,
    output logic [OPERAND_LENGTH-1:0] opd4,
    output logic                      alu_mux1_select,
    output logic [1:0]                alu_mux2_select,
    output logic [3:0]                alu_op_select,
    input  logic [OPERAND_LENGTH-1:0] alu_result,
    input  logic [OPERAND_LENGTH-1:0] comp_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [OPERAND_LENGTH-1:0] res_data,
    output logic [TAG_WIDTH-1:0]      res_tag
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]               stat_ops,
    output logic [15:0]               stat_stall
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 4 * OPERAND_LENGTH + 7 + TAG_WIDTH;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                    state_q;
    logic [ENTRY_W-1:0]        fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      fifoFull, fifoEmpty, push, pop;
    logic [ENTRY_W-1:0]        cmdEntry, headEntry;

    logic [OPERAND_LENGTH-1:0] headOpd1, headOpd2, headOpd3, headOpd4;
    logic                      headMux1;
    logic [1:0]                headMux2;
    logic [3:0]                headOp;
    logic [TAG_WIDTH-1:0]      headTag;

    logic [OPERAND_LENGTH-1:0] opd1_q, opd2_q, opd3_q, opd4_q;
    logic                      mux1_q;
    logic [1:0]                mux2_q;
    logic [3:0]                op_q;
    logic [TAG_WIDTH-1:0]      issueTag_q;
    logic                      resValid_q;
    logic [OPERAND_LENGTH-1:0] resData_q;
    logic [TAG_WIDTH-1:0]      resTag_q;

    assign cmdEntry  = {cmd_opd1, cmd_opd2, cmd_opd3, cmd_opd4,
                        cmd_mux1_select, cmd_mux2_select, cmd_op_select, cmd_tag};
    assign headEntry = fifoMem_q[rdPtr_q];
    assign {headOpd1, headOpd2, headOpd3, headOpd4,
            headMux1, headMux2, headOp, headTag} = headEntry;

    // cmd_ready depends only on the registered count, so a same-cycle pop
    // never lets a command in while the FIFO is full.
    assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign cmd_ready = !fifoFull;
    assign push      = cmd_valid && !fifoFull;

    // Pop when idle, or when the pending result is being accepted. Using the
    // registered count means a command pushed this cycle is not seen yet.
    assign pop = !fifoEmpty && ((state_q == IDLE) || ((state_q == RESP) && res_ready));

    // Next-state for the FIFO pointers and occupancy count. Pointers wrap
    // naturally since the depth is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // FIFO bookkeeping registers; reset discards every queued command.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage needs no reset; only slots below the count are ever read.
    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q] <= cmdEntry;
    end

    // Issue/response FSM with all of its outputs registered. Whenever a pop
    // happens the head command is loaded onto the ALU inputs, so the ALU has
    // the whole EXEC cycle to settle before the result is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opd1_q     <= '0;
            opd2_q     <= '0;
            opd3_q     <= '0;
            opd4_q     <= '0;
            mux1_q     <= 1'b0;
            mux2_q     <= 2'b00;
            op_q       <= 4'b0000;
            issueTag_q <= '0;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resTag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) state_q <= EXEC;
                end
                EXEC: begin
                    resData_q  <= (mux2_q == 2'b11) ? comp_result : alu_result;
                    resTag_q   <= issueTag_q;
                    resValid_q <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        state_q    <= pop ? EXEC : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (pop) begin
                opd1_q     <= headOpd1;
                opd2_q     <= headOpd2;
                opd3_q     <= headOpd3;
                opd4_q     <= headOpd4;
                mux1_q     <= headMux1;
                mux2_q     <= headMux2;
                op_q       <= headOp;
                issueTag_q <= headTag;
            end
        end
    end

    assign opd1            = opd1_q;
    assign opd2            = opd2_q;
    assign opd3            = opd3_q;
    assign opd4            = opd4_q;
    assign alu_mux1_select = mux1_q;
    assign alu_mux2_select = mux2_q;
    assign alu_op_select   = op_q;
    assign res_valid       = resValid_q;
    assign res_data        = resData_q;
    assign res_tag         = resTag_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] statOps_q, statStall_q;

    // Saturating activity counters: completed results and consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            statOps_q   <= '0;
            statStall_q <= '0;
        end else begin
            if (resValid_q && res_ready && (statOps_q != 16'hFFFF))
                statOps_q <= statOps_q + 16'd1;
            if (resValid_q && !res_ready && (statStall_q != 16'hFFFF))
                statStall_q <= statStall_q + 16'd1;
        end
    end

    assign stat_ops   = statOps_q;
    assign stat_stall = statStall_q;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_unit
//
// Directed bench for alu_issue_unit. A small behavioural ALU model answers
// the unit's stimulus; expected results are hand-computed constants.
// Define ALU_ISSUE_STATS_EN to also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_alu_issue_unit;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_opd1, cmd_opd2, cmd_opd3, cmd_opd4;
    logic       cmd_mux1_select;
    logic [1:0] cmd_mux2_select;
    logic [3:0] cmd_op_select;
    logic [3:0] cmd_tag;
    logic [7:0] opd1, opd2, opd3, opd4;
    logic       alu_mux1_select;
    logic [1:0] alu_mux2_select;
    logic [3:0] alu_op_select;
    logic [7:0] alu_result, comp_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_tag;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops, stat_stall;
`endif

    logic [7:0] cmpA, cmpB;
    int compared   = 0;
    int mismatched = 0;
    int accepted;
    int got;
    int stale;

    alu_issue_unit #(
        .OPERAND_LENGTH(8),
        .FIFO_DEPTH    (4),
        .TAG_WIDTH     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_opd1       (cmd_opd1),
        .cmd_opd2       (cmd_opd2),
        .cmd_opd3       (cmd_opd3),
        .cmd_opd4       (cmd_opd4),
        .cmd_mux1_select(cmd_mux1_select),
        .cmd_mux2_select(cmd_mux2_select),
        .cmd_op_select  (cmd_op_select),
        .cmd_tag        (cmd_tag),
        .opd1           (opd1),
        .opd2           (opd2),
        .opd3           (opd3),
        .opd4           (opd4),
        .alu_mux1_select(alu_mux1_select),
        .alu_mux2_select(alu_mux2_select),
        .alu_op_select  (alu_op_select),
        .alu_result     (alu_result),
        .comp_result    (comp_result),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_tag        (res_tag)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops       (stat_ops),
        .stat_stall     (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: adder (1000 = sub), logic (0111 = and), shifter
    // (0011 = shift left), comparison (0111 = less-than unsigned). The main
    // result reads A5 when the comparison unit is selected, so a wrong
    // result-source choice in the unit shows up.
    always_comb begin
        cmpA = alu_mux1_select ? opd3 : opd1;
        cmpB = alu_mux1_select ? opd4 : opd2;
        alu_result = 8'hA5;
        case (alu_mux2_select)
            2'b00:   alu_result = (alu_op_select == 4'b1000) ? opd1 - opd2 : opd1 + opd2;
            2'b01:   alu_result = (alu_op_select == 4'b0111) ? (opd1 & opd2) : (opd1 | opd2);
            2'b10:   alu_result = (alu_op_select == 4'b0011) ? (opd1 << opd2[2:0]) : (opd1 >> opd2[2:0]);
            default: alu_result = 8'hA5;
        endcase
        comp_result = (alu_op_select == 4'b0111) ? {7'b0, (cmpA < cmpB)} : {7'b0, (cmpA == cmpB)};
    end

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] o3,
                                 input logic [7:0] o4, input logic m1, input logic [1:0] m2,
                                 input logic [3:0] op, input logic [3:0] tg);
        cmd_opd1        = o1;
        cmd_opd2        = o2;
        cmd_opd3        = o3;
        cmd_opd4        = o4;
        cmd_mux1_select = m1;
        cmd_mux2_select = m2;
        cmd_op_select   = op;
        cmd_tag         = tg;
    endtask

    // Single command through an idle unit with res_ready held high.
    task automatic runOne(input string name, input logic [7:0] o1, input logic [7:0] o2,
                          input logic [7:0] o3, input logic [7:0] o4, input logic m1,
                          input logic [1:0] m2, input logic [3:0] op, input logic [3:0] tg,
                          input logic [7:0] expData);
        applyStimulus(o1, o2, o3, o4, m1, m2, op, tg);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        checkOutput({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        checkOutput({name, "_valid_t0"}, 32'(res_valid), 32'd0);
        tick();
        checkOutput({name, "_valid_t1"}, 32'(res_valid), 32'd0);
        checkOutput({name, "_mux1"}, 32'(alu_mux1_select), 32'(m1));
        checkOutput({name, "_mux2"}, 32'(alu_mux2_select), 32'(m2));
        tick();
        checkOutput({name, "_valid_t2"}, 32'(res_valid), 32'd1);
        checkOutput({name, "_data"}, 32'(res_data), 32'(expData));
        checkOutput({name, "_tag"}, 32'(res_tag), 32'(tg));
        tick();
        checkOutput({name, "_valid_done"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 4'h0, 4'h0);
        tick();
        tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_opd1", 32'(opd1), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_res_tag", 32'(res_tag), 32'd0);
        rst = 1'b0;
        tick();

        // ADD 3 + 8
        runOne("add", 8'd3, 8'd8, 8'd0, 8'd0, 1'b0, 2'b00, 4'b0000, 4'd1, 8'h0B);
        checkOutput("add_opd1", 32'(opd1), 32'd3);
        checkOutput("add_opd2", 32'(opd2), 32'd8);

        // Back-to-back SUB, AND, SLL with res_ready high
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        applyStimulus(8'd10, 8'd12, 8'd0, 8'd0, 1'b0, 2'b00, 4'b1000, 4'd2);
        tick();
        applyStimulus(8'hCC, 8'hFF, 8'd0, 8'd0, 1'b0, 2'b01, 4'b0111, 4'd3);
        tick();
        applyStimulus(8'h0F, 8'd3, 8'd0, 8'd0, 1'b0, 2'b10, 4'b0011, 4'd4);
        tick();
        cmd_valid = 1'b0;
        checkOutput("b2b_sub_valid", 32'(res_valid), 32'd1);
        checkOutput("b2b_sub_data", 32'(res_data), 32'hFE);
        checkOutput("b2b_sub_tag", 32'(res_tag), 32'd2);
        tick();
        checkOutput("b2b_gap1", 32'(res_valid), 32'd0);
        tick();
        checkOutput("b2b_and_valid", 32'(res_valid), 32'd1);
        checkOutput("b2b_and_data", 32'(res_data), 32'hCC);
        checkOutput("b2b_and_tag", 32'(res_tag), 32'd3);
        tick();
        checkOutput("b2b_gap2", 32'(res_valid), 32'd0);
        tick();
        checkOutput("b2b_sll_valid", 32'(res_valid), 32'd1);
        checkOutput("b2b_sll_data", 32'(res_data), 32'h78);
        checkOutput("b2b_sll_tag", 32'(res_tag), 32'd4);
        tick();
        checkOutput("b2b_idle", 32'(res_valid), 32'd0);

        // Comparisons on the opd3/opd4 pair; opd1/opd2 would give the opposite answer
        runOne("ltu1", 8'd5, 8'd2, 8'h00, 8'h01, 1'b1, 2'b11, 4'b0111, 4'd5, 8'h01);
        runOne("ltu0", 8'd1, 8'd2, 8'hFF, 8'hFC, 1'b1, 2'b11, 4'b0111, 4'd6, 8'h00);

        // Backpressure: six offers, five accepted
        res_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'(8'h10 + i), 8'd1, 8'd0, 8'd0, 1'b0, 2'b00, 4'b0000, 4'(5 + i));
            cmd_valid = 1'b1;
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        checkOutput("bp_accepted", 32'(accepted), 32'd5);
        checkOutput("bp_cmd_ready_full", 32'(cmd_ready), 32'd0);
        checkOutput("bp_valid", 32'(res_valid), 32'd1);
        checkOutput("bp_data", 32'(res_data), 32'h11);
        tick();
        tick();
        tick();
        checkOutput("bp_hold_valid", 32'(res_valid), 32'd1);
        checkOutput("bp_hold_data", 32'(res_data), 32'h11);
        checkOutput("bp_hold_tag", 32'(res_tag), 32'd5);
        checkOutput("bp_hold_ready", 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        checkOutput("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
        got = 1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (res_valid) begin
                checkOutput("bp_order_data", 32'(res_data), 32'(8'h11 + got));
                checkOutput("bp_order_tag", 32'(res_tag), 32'(5 + got));
                got++;
            end
            tick();
        end
        checkOutput("bp_result_count", 32'(got), 32'd5);
        tick();
        checkOutput("bp_drained", 32'(res_valid), 32'd0);

        // Reset while in RESP with three commands queued
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(8'h40 + i), 8'd1, 8'd0, 8'd0, 1'b0, 2'b01, 4'b0110, 4'(i + 1));
            tick();
        end
        cmd_valid = 1'b0;
        checkOutput("rmid_valid_before", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rmid_valid", 32'(res_valid), 32'd0);
        checkOutput("rmid_opd1", 32'(opd1), 32'd0);
        checkOutput("rmid_mux2", 32'(alu_mux2_select), 32'd0);
        checkOutput("rmid_op", 32'(alu_op_select), 32'd0);
        checkOutput("rmid_data", 32'(res_data), 32'd0);
        checkOutput("rmid_cmd_ready", 32'(cmd_ready), 32'd1);
        res_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (res_valid) stale++;
        end
        checkOutput("rmid_stale", 32'(stale), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
        // Three ops, the first held by the consumer for four cycles
        checkOutput("stat_ops_rst", 32'(stat_ops), 32'd0);
        applyStimulus(8'd1, 8'd1, 8'd0, 8'd0, 1'b0, 2'b00, 4'b0000, 4'd7);
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        repeat (4) tick();
        res_ready = 1'b1;
        tick();
        runOne("st2", 8'd2, 8'd2, 8'd0, 8'd0, 1'b0, 2'b00, 4'b0000, 4'd8, 8'h04);
        runOne("st3", 8'd3, 8'd3, 8'd0, 8'd0, 1'b0, 2'b00, 4'b0000, 4'd9, 8'h06);
        checkOutput("stat_ops", 32'(stat_ops), 32'd3);
        checkOutput("stat_stall", 32'(stat_stall), 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
